// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the request arbiter: response codes, arbiter
// states and default bus widths.
package axi_lite_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_idx, wrapping, so last_idx itself has the lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan the requesters in rotated order and keep only the first hit.
    always_comb begin
        int cand_v;
        int raw_v;
        logic hit_v;
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        cand_v = 0;
        raw_v  = 0;
        hit_v  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            raw_v       = int'(last_idx) + off;
            cand_v      = (raw_v >= NUM_REQ) ? (raw_v - NUM_REQ) : raw_v;
            hit_v       = req[cand_v] & ~any;
            grant[cand_v] = hit_v;
            idx         = hit_v ? IDX_W'(cand_v) : idx;
            any         = any | hit_v;
        end
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among
// NUM_REQ requesters, with per-requester response handshake and a WAIT timeout.
module axi_lite_req_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    output logic                        start_read,
    output logic                        start_write,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           data,
    input  logic                        mst_done,
    input  logic [DATA_W-1:0]           mst_rdata,
    input  logic [1:0]                  mst_resp,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    arb_state_t          state_r;
    logic [IDX_W-1:0]    last_grant_r;
    logic [IDX_W-1:0]    grant_id_r;
    logic                wr_r;
    logic [TMR_W-1:0]    timer_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic                start_read_r;
    logic                start_write_r;
    logic                busy_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic [1:0]          rsp_resp_r;
    logic                rsp_timeout_r;

    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [NUM_REQ-1:0]  grant_onehot_s;
    logic                rsp_hs_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req_valid),
        .last_idx (last_grant_r),
        .grant    (pick_onehot_s),
        .idx      (pick_idx_s),
        .any      (pick_any_s)
    );

    // AND-OR mux of the picked requester's command fields.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{pick_onehot_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{pick_onehot_s[i]}});
        end
    end

    assign sel_write_s    = |(req_write & pick_onehot_s);
    assign grant_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
    assign rsp_hs_s       = |(rsp_valid_r & rsp_ready);

    // Accept is only visible while idle and out of reset, so a reset cycle never looks like a grant.
    assign req_ready = (state_r == IDLE && !areset) ? pick_onehot_s : '0;

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= IDLE;
            last_grant_r  <= IDX_W'(NUM_REQ - 1);
            grant_id_r    <= '0;
            wr_r          <= 1'b0;
            timer_r       <= '0;
            addr_r        <= '0;
            data_r        <= '0;
            start_read_r  <= 1'b0;
            start_write_r <= 1'b0;
            busy_r        <= 1'b0;
            rsp_valid_r   <= '0;
            rsp_rdata_r   <= '0;
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_id_r    <= pick_idx_s;
                        wr_r          <= sel_write_s;
                        addr_r        <= sel_addr_s;
                        data_r        <= sel_wdata_s;
                        start_read_r  <= ~sel_write_s;
                        start_write_r <= sel_write_s;
                        busy_r        <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_read_r  <= 1'b0;
                    start_write_r <= 1'b0;
                    timer_r       <= '0;
                    state_r       <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last timeout cycle still wins.
                    if (mst_done) begin
                        rsp_rdata_r   <= wr_r ? '0 : mst_rdata;
                        rsp_resp_r    <= mst_resp;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= grant_onehot_s;
                        state_r       <= RESP;
                    end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                        rsp_rdata_r   <= '0;
                        rsp_resp_r    <= RESP_SLVERR;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= grant_onehot_s;
                        state_r       <= RESP;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r   <= '0;
                        rsp_rdata_r   <= '0;
                        rsp_resp_r    <= RESP_OKAY;
                        rsp_timeout_r <= 1'b0;
                        last_grant_r  <= grant_id_r;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_timeout = rsp_timeout_r;
    assign start_read  = start_read_r;
    assign start_write = start_write_r;
    assign addr        = addr_r;
    assign data        = data_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed self-checking bench for axi_lite_req_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_axi_lite_req_arbiter;

    logic         aclk = 1'b0;
    logic         areset;
    logic [3:0]   req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  rsp_rdata, addr, data, mst_rdata;
    logic [1:0]   rsp_resp, mst_resp, grant_id;
    logic         rsp_timeout, start_read, start_write, mst_done, busy;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_req_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .start_read  (start_read),
        .start_write (start_write),
        .addr        (addr),
        .data        (data),
        .mst_done    (mst_done),
        .mst_rdata   (mst_rdata),
        .mst_resp    (mst_resp),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if ({start_read, start_write} !== 2'b00) begin n_err++; $display("FAIL reset_start: got %b expected 00", {start_read, start_write}); end
        n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_valid_ready: got %b/%b expected 0000/0000", rsp_valid, req_ready); end
        n_cmp++; if ({addr, data, rsp_rdata} !== 96'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {addr, data, rsp_rdata}); end
        n_cmp++; if ({grant_id, rsp_resp, rsp_timeout} !== 5'd0) begin n_err++; $display("FAIL reset_misc: got %b expected 00000", {grant_id, rsp_resp, rsp_timeout}); end
    endtask

    task automatic test_single_read();
        int pulses;
        pulses = 0;
        req_addr[31:0] = 32'h0000_0010;
        req_write = 4'b0000;
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_req_ready: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_cmp++; if ({start_read, start_write} !== 2'b10) begin n_err++; $display("FAIL rd_start: got %b expected 10", {start_read, start_write}); end
        n_cmp++; if (addr !== 32'h10 || busy !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("FAIL rd_issue: got addr=%h busy=%b gid=%0d expected 10/1/0", addr, busy, grant_id); end
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses += int'(start_read) + int'(start_write);
            n_cmp++; if (addr !== 32'h10 || rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rd_wait_hold: got addr=%h rsp_valid=%b expected 10/0000", addr, rsp_valid); end
        end
        mst_done = 1'b1; mst_rdata = 32'hDEAD_BEEF; mst_resp = 2'b00;
        tick();
        mst_done = 1'b0; mst_rdata = 32'h0;
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rd_single_pulse: got %0d extra pulses expected 0", pulses); end
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL rd_rsp_valid: got %b expected 0001", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin n_err++; $display("FAIL rd_rsp_data: got %h/%b/%b expected deadbeef/00/0", rsp_rdata, rsp_resp, rsp_timeout); end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL rd_complete: got %b/%b expected 0000/0", rsp_valid, busy); end
    endtask

    task automatic test_write();
        req_addr[95:64]  = 32'h0000_0024;
        req_wdata[95:64] = 32'h5A5A_5A5A;
        req_write = 4'b0100;
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wr_req_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_cmp++; if ({start_read, start_write} !== 2'b01) begin n_err++; $display("FAIL wr_start: got %b expected 01", {start_read, start_write}); end
        n_cmp++; if (data !== 32'h5A5A_5A5A || addr !== 32'h24 || grant_id !== 2'd2) begin n_err++; $display("FAIL wr_issue: got %h/%h/%0d expected 5a5a5a5a/24/2", data, addr, grant_id); end
        tick();
        mst_done = 1'b1; mst_rdata = 32'h1234_5678; mst_resp = 2'b10;
        tick();
        mst_done = 1'b0;
        n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL wr_rsp_valid: got %b expected 0100", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b10 || start_write !== 1'b0) begin n_err++; $display("FAIL wr_rsp_data: got %h/%b/%b expected 0/10/0", rsp_rdata, rsp_resp, start_write); end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = 4'b0000;
        req_write = 4'b0000;
    endtask

    task automatic test_round_robin();
        int exp;
        logic [3:0] exp_oh;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            exp_oh = 4'b0001 << exp;
            #1;
            n_cmp++; if (req_ready !== exp_oh) begin n_err++; $display("FAIL rr_order[%0d]: got %b expected %b", k, req_ready, exp_oh); end
            tick();
            n_cmp++; if (grant_id !== 2'(exp) || start_read !== 1'b1 || addr !== 32'h100 + 32'(exp * 4)) begin n_err++; $display("FAIL rr_issue[%0d]: got gid=%0d sr=%b addr=%h expected %0d/1/%h", k, grant_id, start_read, addr, exp, 32'h100 + 32'(exp * 4)); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_ready_issue[%0d]: got %b expected 0000", k, req_ready); end
            tick();
            mst_done = 1'b1; mst_rdata = 32'hA000_0000 | 32'(exp); mst_resp = 2'b00;
            tick();
            mst_done = 1'b0;
            n_cmp++; if (rsp_valid !== exp_oh || rsp_rdata !== (32'hA000_0000 | 32'(exp))) begin n_err++; $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid, rsp_rdata, exp_oh, 32'hA000_0000 | 32'(exp)); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_ready_resp[%0d]: got %b expected 0000", k, req_ready); end
            rsp_ready = exp_oh;
            tick();
            rsp_ready = 4'b0000;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        req_addr[63:32] = 32'h0000_0200;
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL to_req_ready: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        for (int k = 0; k < 15; k++) begin
            n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL to_early[%0d]: got %b/%b expected 0000/1", k, rsp_valid, busy); end
            tick();
        end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL to_last_wait: got %b expected 0000", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_timeout !== 1'b1) begin n_err++; $display("FAIL to_fire: got %b/%b expected 0010/1", rsp_valid, rsp_timeout); end
        n_cmp++; if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL to_resp: got %b/%h expected 10/0", rsp_resp, rsp_rdata); end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
        req_addr[127:96] = 32'h0000_0300;
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL to_next_ready: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        mst_done = 1'b1; mst_rdata = 32'hCAFE_F00D; mst_resp = 2'b00;
        tick();
        mst_done = 1'b0;
        n_cmp++; if (rsp_valid !== 4'b1000 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b00) begin n_err++; $display("FAIL to_next_rsp: got %b/%b/%h/%b expected 1000/0/cafef00d/00", rsp_valid, rsp_timeout, rsp_rdata, rsp_resp); end
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_rsp_stall();
        req_addr[31:0] = 32'h0000_0040;
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL st_req_ready: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b1110;
        tick();
        mst_done = 1'b1; mst_rdata = 32'h0BAD_F00D; mst_resp = 2'b01;
        tick();
        mst_done = 1'b0; mst_rdata = 32'h0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h0BAD_F00D || rsp_resp !== 2'b01) begin n_err++; $display("FAIL st_hold[%0d]: got %b/%h/%b expected 0001/0badf00d/01", k, rsp_valid, rsp_rdata, rsp_resp); end
            n_cmp++; if ({start_read, start_write} !== 2'b00 || req_ready !== 4'b0000) begin n_err++; $display("FAIL st_quiet[%0d]: got %b/%b expected 00/0000", k, {start_read, start_write}, req_ready); end
            tick();
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin n_err++; $display("FAIL st_after: got %b/%b expected 0000/0000", req_ready, rsp_valid); end
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0 || start_read !== 1'b0) begin n_err++; $display("FAIL st_withdrawn: got %b/%b expected 0/0", busy, start_read); end
    endtask

    task automatic test_reset_mid();
        req_addr[63:32] = 32'h0000_0088;
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rm_req_ready: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || grant_id !== 2'd0 || addr !== 32'h0 || data !== 32'h0) begin n_err++; $display("FAIL rm_cleared: got %b/%0d/%h/%h expected 0/0/0/0", busy, grant_id, addr, data); end
        n_cmp++; if (rsp_valid !== 4'b0000 || {start_read, start_write, rsp_timeout} !== 3'b000 || rsp_resp !== 2'b00) begin n_err++; $display("FAIL rm_outputs: got %b/%b/%b expected 0000/000/00", rsp_valid, {start_read, start_write, rsp_timeout}, rsp_resp); end
        mst_done = 1'b1; mst_rdata = 32'hFFFF_FFFF; mst_resp = 2'b00;
        tick();
        mst_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rm_late_done[%0d]: got %b/%b/%h expected 0000/0/0", k, rsp_valid, busy, rsp_rdata); end
            tick();
        end
    endtask

    initial begin
        areset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0; mst_done = 1'b0; mst_rdata = '0; mst_resp = 2'b00;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_rsp_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
